keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000; clk cycles per scan tick.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4; consecutive stable ticks needed for press and for release.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port col_in  input  4  keypad columns, active-low, asynchronous; bit i = column i.
REQ-006 SHALL have port row_out  output  4  row strobe, active-low, exactly one bit low; bit i = row i.
REQ-007 SHALL have port key_code  output  4  code of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse per accepted key press.
REQ-009 SHALL have ports digit0, digit1, digit2, digit3  output  4 each  entered BCD digits; digit0 least significant.
REQ-010 SHALL have port entry_done  output  1  one-cycle pulse when '#' is accepted.

Function
REQ-011 SHALL pass col_in through a 2-flop synchronizer before any use.
REQ-012 SHALL generate a one-cycle scan tick every SCAN_DIV clk cycles as an enable, not as a derived clock.
REQ-013 SHALL cycle row_out 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing only on a tick while in SCAN.
REQ-014 SHALL sample synchronized columns only on a tick, before any row advance that tick.
REQ-015 SHALL implement states SCAN, DEBOUNCE, HELD.
REQ-016 SCAN on tick: exactly one column low -> capture row/column, count=1, go DEBOUNCE, row frozen; no column or more than one column low -> advance row, stay SCAN.
REQ-017 DEBOUNCE on tick: same single column low -> count+1; on count reaching DEBOUNCE_SCANS -> key_valid high next cycle with key_code, go HELD; any other pattern -> return to SCAN and advance row.
REQ-018 HELD on tick: all columns high -> release count+1, else release count=0; on DEBOUNCE_SCANS consecutive all-high ticks -> SCAN and advance row; no auto-repeat.
REQ-019 SHALL map (row,col): row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 *,0,#,D; codes = digit value, A-D = 0xA-0xD, * = 0xE, # = 0xF.
REQ-020 SHALL hold key_code between pulses; key_valid high exactly one cycle per accepted press.
REQ-021 On key_valid with code 0-9: digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=code, visible the cycle after key_valid.
REQ-022 On key_valid with 0xE: all digits <=0, same timing.
REQ-023 On key_valid with 0xF: entry_done high the cycle after key_valid for one cycle; digits unchanged.
REQ-024 Codes 0xA-0xD: key_valid/key_code only; digits and entry_done unaffected.
REQ-025 Fifth digit entered SHALL discard the old digit3 (no saturation).
REQ-026 Second key pressed while in HELD SHALL be ignored until full release.

Reset
REQ-027 Reset SHALL force: row_out=1110, key_code=0, key_valid=0, entry_done=0, digits=0, state SCAN, tick/debounce/release counters 0, synchronizer 1111.
REQ-028 Reset asserted mid-DEBOUNCE or HELD SHALL abort with no key_valid pulse after release of reset until a fresh full debounce.

Structure
REQ-029 SHALL place state enum, row strobe patterns, 4x4 key map table and special codes (0xE clear, 0xF enter) in shared package keypad_pkg.
REQ-030 SHALL implement tick generation in sub-module scan_tick_gen (parameter SCAN_DIV, outputs one-cycle tick).

Verification (SCAN_DIV=10, DEBOUNCE_SCANS=4)
REQ-031 Reset -> row_out=1110, all digits 0, key_valid=0, row_out rotating every 10 cycles.
REQ-032 Hold col_in=1101 whenever row_out=1101 (key '5'), stable 6 ticks -> exactly one key_valid, key_code=5, digit0=5.
REQ-033 Press '5' with bounce (released at 2nd debounce tick) -> no key_valid; row resumes rotation.
REQ-034 Keys 1,2,3,4,9 pressed/released in turn -> digit3..0 = 2,3,4,9; then '*' -> all digits 0.
REQ-035 Press '#' -> key_code=0xF, entry_done one cycle after key_valid, digits unchanged; two columns low together -> no key_valid.
REQ-036 Reset asserted at 3rd debounce tick of '7' -> no key_valid; outputs return to reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad types: scanner states, row strobes, key map.
// Codes: 0-9 digits, A-D letters, E clear (*), F enter (#).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  // Active-low strobe for each row index.
  localparam logic [3:0] ROW_PAT [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  // KEY_MAP[row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] CODE_CLEAR = 4'hE;
  localparam logic [3:0] CODE_ENTER = 4'hF;

  function automatic logic [3:0] key_lookup(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return KEY_MAP[r][c];
  endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// scan_tick_gen: one-cycle enable pulse every SCAN_DIV clocks.
// Ports: clk, reset (async high) in; tick out.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and 4-digit BCD entry.
// Ports: clk, reset, col_in in; row_out, key_code, key_valid, digit0-3, entry_done out.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       entry_done
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DS = CW'(DEBOUNCE_SCANS);

  logic          tick;
  logic [3:0]    col_m, col_s;
  state_t        state, state_n;
  logic [1:0]    row_idx, row_n;
  logic [1:0]    col_idx, col_n;
  logic [CW-1:0] deb_cnt, deb_n;
  logic [CW-1:0] rel_cnt, rel_n;
  logic          accept;
  logic          one_low;
  logic [1:0]    low_idx;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign row_out = ROW_PAT[row_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    row_n   = row_idx;
    col_n   = col_idx;
    deb_n   = deb_cnt;
    rel_n   = rel_cnt;
    accept  = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_low) begin
            col_n = low_idx;
            deb_n = CW'(1);
            rel_n = '0;
            if (deb_n == DS) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (one_low && low_idx == col_idx) begin
            deb_n = deb_cnt + 1'b1;
            if (deb_n == DS) begin
              accept  = 1'b1;
              rel_n   = '0;
              state_n = HELD;
            end
          end else begin
            deb_n   = '0;
            row_n   = row_idx + 2'd1;
            state_n = SCAN;
          end
        end
        HELD: begin
          if (col_s == 4'hF) begin
            rel_n = rel_cnt + 1'b1;
            if (rel_n == DS) begin
              rel_n   = '0;
              deb_n   = '0;
              row_n   = row_idx + 2'd1;
              state_n = SCAN;
            end
          end else begin
            rel_n = '0;
          end
        end
        default: begin
          state_n = SCAN;
          deb_n   = '0;
          rel_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      state     <= state_n;
      row_idx   <= row_n;
      col_idx   <= col_n;
      deb_cnt   <= deb_n;
      rel_cnt   <= rel_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= key_lookup(row_idx, col_n);
      end
    end
  end

  // Digit entry acts on the registered pulse, one cycle after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit0     <= 4'h0;
      digit1     <= 4'h0;
      digit2     <= 4'h0;
      digit3     <= 4'h0;
      entry_done <= 1'b0;
    end else begin
      entry_done <= key_valid && (key_code == CODE_ENTER);
      if (key_valid) begin
        unique case (1'b1)
          (key_code <= 4'd9): begin
            digit3 <= digit2;
            digit2 <= digit1;
            digit1 <= digit0;
            digit0 <= key_code;
          end
          (key_code == CODE_CLEAR): begin
            digit0 <= 4'h0;
            digit1 <= 4'h0;
            digit2 <= 4'h0;
            digit3 <= 4'h0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
